servo_track_ctrl: RTL

Multi-channel pan/tilt servo tracking controller. It replaces the per-axis coordinate-to-PWM pair with one block of N_CH channels. All channels share one microsecond prescaler and one frame counter. Each channel has a proportional, rate-limited step, a deadband, per-channel direction inversion and target-loss detection. The block sits between the ISP target-centroid stage and the servo pins.

---
 rtl/servo_track_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/servo_track_ctrl.sv
// Multi-channel pan/tilt servo tracker: shared us prescaler and frame counter, per-channel
// proportional rate-limited stepping with deadband and loss detection. Option: HOME_ON_LOST_EN.
module servo_track_ctrl #(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned CW           = 11,
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned PERIOD_US    = 20000,
  parameter int unsigned MIN_HIGH_US  = 500,
  parameter int unsigned MAX_HIGH_US  = 2500,
  parameter int unsigned INIT_HIGH_US = 1500,
  parameter int unsigned THRESHOLD    = 2,
  parameter int unsigned GAIN_SHIFT   = 3,
  parameter int unsigned MAX_STEP_US  = 20,
  parameter int unsigned LOST_FRAMES  = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      coord_valid,
  input  logic [N_CH*CW-1:0]   coord,
  input  logic [N_CH*CW-1:0]   goal,
  input  logic [N_CH-1:0]      dir_inv,
  output logic [N_CH-1:0]      pwm,
  output logic [N_CH*15-1:0]   high_us,
  output logic [14:0]          ct_us,
  output logic                 frame_tick,
  output logic [N_CH-1:0]      lost
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MW = $clog2(LOST_FRAMES + 1);
  localparam logic [PW-1:0] PrescLast = PW'(CLK_DIV - 1);
  localparam logic [14:0]   CtLast    = 15'(PERIOD_US - 1);
  localparam logic [MW-1:0] MissMax   = MW'(LOST_FRAMES);
  localparam logic [14:0]   InitHigh  = 15'(INIT_HIGH_US);

  typedef enum logic [1:0] {StTrack, StCoast, StLost} ch_state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [14:0]   ct_q, ct_d;
  logic          tick_q;
  logic          us_tick, fb;

  always_comb begin
    us_tick = (presc_q == PrescLast);
    fb      = us_tick && (ct_q == CtLast);
    presc_d = us_tick ? '0 : presc_q + 1'b1;
    ct_d    = ct_q;
    if (us_tick) ct_d = fb ? '0 : ct_q + 15'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      ct_q    <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ct_q    <= ct_d;
      tick_q  <= fb;
    end
  end

  assign ct_us      = ct_q;
  assign frame_tick = tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_e     state_q, state_d;
    logic [CW-1:0] lat_q, lat_d, coord_i, goal_i;
    logic          fresh_q, fresh_d;
    logic [MW-1:0] miss_q, miss_d;
    logic [14:0]   high_q, high_d, track_high;
    logic          pwm_q;
    int            err, mag, step, tgt;

    assign coord_i = coord[i*CW +: CW];
    assign goal_i  = goal[i*CW +: CW];

    // Integer arithmetic keeps the signed error and the saturation free of width pitfalls.
    always_comb begin
      err  = int'(lat_q) - int'(goal_i);
      mag  = (err < 0) ? -err : err;
      step = mag >> GAIN_SHIFT;
      if (step < 1) step = 1;
      else if (step > int'(MAX_STEP_US)) step = int'(MAX_STEP_US);
      tgt = ((err > 0) ^ dir_inv[i]) ? int'(high_q) + step : int'(high_q) - step;
      if (tgt < int'(MIN_HIGH_US)) tgt = int'(MIN_HIGH_US);
      else if (tgt > int'(MAX_HIGH_US)) tgt = int'(MAX_HIGH_US);
      track_high = 15'(tgt);
    end

`ifdef HOME_ON_LOST_EN
    localparam logic [14:0] StepMax = 15'(MAX_STEP_US);
    logic [14:0] home_high;

    always_comb begin
      home_high = InitHigh;
      if (high_q > InitHigh) begin
        if (high_q - InitHigh > StepMax) home_high = high_q - StepMax;
      end else if (InitHigh - high_q > StepMax) begin
        home_high = high_q + StepMax;
      end
    end
`endif

    always_comb begin
      state_d = state_q;
      miss_d  = miss_q;
      high_d  = high_q;
      lat_d   = lat_q;
      fresh_d = fresh_q;
      if (fb) begin
        if (fresh_q) begin
          if (mag > int'(THRESHOLD)) high_d = track_high;
          fresh_d = 1'b0;
          miss_d  = '0;
          state_d = StTrack;
        end else begin
          if (miss_q < MissMax) miss_d = miss_q + 1'b1;
          state_d = (miss_d == MissMax) ? StLost : StCoast;
`ifdef HOME_ON_LOST_EN
          if (state_q == StLost) high_d = home_high;
`endif
        end
      end
      // A capture in the boundary cycle lands after the boundary consumed the old sample.
      if (coord_valid[i]) begin
        lat_d   = coord_i;
        fresh_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= StCoast;
        miss_q  <= '0;
        high_q  <= InitHigh;
        lat_q   <= '0;
        fresh_q <= 1'b0;
        pwm_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        miss_q  <= miss_d;
        high_q  <= high_d;
        lat_q   <= lat_d;
        fresh_q <= fresh_d;
        pwm_q   <= (ct_q < high_q);
      end
    end

    assign pwm[i]               = pwm_q;
    assign lost[i]              = (state_q == StLost);
    assign high_us[i*15 +: 15]  = high_q;
  end

endmodule
